// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory model.
// Holds the FSM state encoding, the word width and the address range helper.
package mem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // An address is out of range when any bit above the word index field is set.
  function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr, input int idx_w);
    logic [WORD_W-1:0] hi;
    hi = addr >> (idx_w + 2);
    return (hi != {WORD_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a CPU (master) and mem_responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port word store: synchronous write, read data captured on the access edge.
// The storage itself is never reset; only the read capture register is.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     we,
  input  logic                     err,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] rdata_r;

  // Word write; rejected requests never touch the storage.
  always_ff @(posedge clock) begin
    if (en && we && !err) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read capture; stores and errors return zero, cleared after the handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= {WORD_W{1'b0}};
    end else if (en) begin
      rdata_r <= (we || err) ? {WORD_W{1'b0}} : mem_r[idx];
    end else if (clr) begin
      rdata_r <= {WORD_W{1'b0}};
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, answers after LATENCY edges.
// Optional misalignment error check enabled by defining MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r;
  logic [WORD_W-1:0] addr_r;
  logic [WORD_W-1:0] wdata_r;
  logic              resp_valid_r;
  logic              resp_err_r;

  logic              req_ready_s;
  logic              access_s;
  logic              handshake_s;
  logic              err_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WORD_W-1:0] rdata_s;

  // Decode of the latched request and FSM qualifiers.
  always_comb begin
    req_ready_s = (state_r == IDLE);
    access_s    = (state_r == BUSY) && (cnt_r == {CNT_W{1'b0}});
    handshake_s = (state_r == RESP) && bus.resp_ready;
    idx_s       = addr_r[IDX_W+1:2];
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    err_s       = addr_out_of_range(addr_r, IDX_W) || (addr_r[1:0] != 2'b00);
`else
    err_s       = addr_out_of_range(addr_r, IDX_W);
`endif
  end

  // Request/response FSM; request fields are only sampled on the accept edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      we_r         <= 1'b0;
      addr_r       <= {WORD_W{1'b0}};
      wdata_r      <= {WORD_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid && req_ready_s) begin
            we_r    <= bus.req_we;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            cnt_r   <= CNT_INIT;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (access_s) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= err_s;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= {CNT_W{1'b0}};
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  mem_responder_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (access_s),
    .we     (we_r),
    .err    (err_s),
    .clr    (handshake_s),
    .idx    (idx_s),
    .wdata  (wdata_r),
    .rdata  (rdata_s)
  );

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = rdata_s;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus scoreboard, reset corner cases.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  mem_responder_if bus();

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Garbage on the request bus while the responder is busy must be ignored.
  task automatic scramble();
    bus.req_valid = 1'b1;
    bus.req_we    = ~bus.req_we;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      timeout("req_ready");
    end else begin
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(posedge clock);
    end
  endtask

  // Returns at the first negedge that shows resp_valid, checking the edge count.
  task automatic await_resp(input string name, output bit ok);
    int lat;
    lat = 0;
    ok  = 1'b0;
    @(negedge clock);
    scramble();
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (bus.resp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      scramble();
    end
    if (!ok) timeout({name, "_resp_valid"});
    else     check({name, "_latency"}, lat, LATENCY);
  endtask

  task automatic transact(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
    bit   ok;
    exp_t e;
    start(we, addr, wdata, ok);
    if (!ok) return;
    sb.push_back('{exp_rdata, exp_err});
    await_resp(name, ok);
    if (!ok) begin
      bus.req_valid = 1'b0;
      sb.delete();
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_valid"}, bus.resp_valid, 1);
      check({name, "_hold_rdata"}, bus.resp_rdata, e.rdata);
      check({name, "_hold_req_ready"}, bus.req_ready, 0);
      @(posedge clock);
      @(negedge clock);
      scramble();
    end
    check({name, "_rdata"}, bus.resp_rdata, e.rdata);
    check({name, "_err"}, bus.resp_err, e.err);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check({name, "_valid_drop"}, bus.resp_valid, 0);
    check({name, "_req_ready_back"}, bus.req_ready, 1);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;

    vecs[0]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 1'b0, 0};
    vecs[1]  = '{1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 1'b0, 5};
    vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0000, 1'b0, 0};
    vecs[4]  = '{1'b0, 32'h0000_0022, 32'h0, ALIGN ? 32'h0 : 32'hDEAD_BEEF, ALIGN, 0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'h1111_1111, 32'h0, 1'b1, 0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0000, 1'b0, 0};
    vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 0};
    vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 0};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 0};
    vecs[10] = '{1'b1, 32'h0000_0021, 32'h2121_2121, 32'h0, ALIGN, 0};
    vecs[11] = '{1'b0, 32'h0000_0020, 32'h0, ALIGN ? 32'hDEAD_BEEF : 32'h2121_2121, 1'b0, 0};
    vecs[12] = '{1'b0, 32'h0000_0040, 32'h0, 32'h4040_4040, 1'b0, 2};

    #2;
    check("reset_resp_valid", bus.resp_valid, 0);
    check("reset_resp_rdata", bus.resp_rdata, 32'h0);
    check("reset_resp_err", bus.resp_err, 0);
    check("reset_req_ready", bus.req_ready, 1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    transact("preload0", 1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0, 1'b0, 0);
    transact("preload8", 1'b1, 32'h0000_0020, 32'h0000_0808, 32'h0, 1'b0, 0);
    transact("preload16", 1'b1, 32'h0000_0040, 32'h4040_4040, 32'h0, 1'b0, 0);

    for (int i = 0; i < 13; i++) begin
      transact($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].hold);
    end

    // Reset while a store is in flight: outputs clear at once, the store is dropped.
    start(1'b1, 32'h0000_0040, 32'h1234_5678, ok);
    if (ok) begin
      @(negedge clock);
      scramble();
      #2 reset_n = 1'b0;
      #1;
      check("rst_busy_valid", bus.resp_valid, 0);
      check("rst_busy_rdata", bus.resp_rdata, 32'h0);
      check("rst_busy_err", bus.resp_err, 0);
      bus.req_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
    end
    transact("after_rst_load40", 1'b0, 32'h0000_0040, 32'h0, 32'h4040_4040, 1'b0, 0);

    // Reset while a load response is being presented.
    start(1'b0, 32'h0000_0000, 32'h0, ok);
    if (ok) begin
      await_resp("rst_resp", ok);
      if (ok) begin
        check("rst_resp_pre_rdata", bus.resp_rdata, 32'hA5A5_0000);
        #1 reset_n = 1'b0;
        #1;
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_req_ready", bus.req_ready, 1);
      end
      bus.req_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
    end
    transact("final_load0", 1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
